// File: rtl/sort_relu_if.sv
// sort_relu_if
//   Bundles the streaming input, the head outputs and the read port of the
//   ReLU + top-K sorter. Clock and reset stay plain ports on the design.
//
//   Signals
//     in              score, signed two's complement, taken every clock
//     index           tag stored alongside the score
//     asce            1 = keep smallest (list[0] = min), 0 = keep largest
//     value_out       registered value of list[0]
//     value_index_out registered index of list[0]
//     count           number of valid entries, 0..DEPTH
//     rd_addr         read address into the list
//     rd_value        value of list[rd_addr], 0 when that entry is invalid
//     rd_index        index of list[rd_addr], 0 when that entry is invalid
//
//   Modports: master drives stimulus and the read address, slave is the sorter.
interface sort_relu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] index;
    logic              asce;
    logic [DATA_W-1:0] value_out;
    logic [DATA_W-1:0] value_index_out;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_value;
    logic [DATA_W-1:0] rd_index;

    modport master (
        output in,
        output index,
        output asce,
        output rd_addr,
        input  value_out,
        input  value_index_out,
        input  count,
        input  rd_value,
        input  rd_index
    );

    modport slave (
        input  in,
        input  index,
        input  asce,
        input  rd_addr,
        output value_out,
        output value_index_out,
        output count,
        output rd_value,
        output rd_index
    );
endinterface

// File: rtl/sort_relu.sv
// sort_relu
//   Streaming ReLU plus top-K sorter. One score/tag pair is taken on every
//   rising clock edge, negative scores are clamped to zero, and the result is
//   inserted into a register-based sorted list of DEPTH entries in a single
//   cycle. The best entry is presented on value_out/value_index_out (registered);
//   any entry can be read combinationally through rd_addr/rd_value/rd_index.
//
//   Ports
//     clk  rising-edge clock
//     rst  synchronous, active-low reset
//     bus  sort_relu_if slave: in, index, asce, value_out, value_index_out,
//          count, rd_addr, rd_value, rd_index
//
//   Insertion: the new element is compared against every entry in parallel.
//   A slot is a candidate if the element is strictly better than the entry
//   there or if the slot is empty; the first candidate wins. Strictly-better
//   keeps ties stable (later arrivals go behind equal entries) and makes a
//   full list silently discard anything not better than its last entry.
module sort_relu #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    sort_relu_if.slave bus
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] val_q [DEPTH];
    logic [DATA_W-1:0] idx_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic              asce_q;
    logic [DATA_W-1:0] head_val_q;
    logic [DATA_W-1:0] head_idx_q;

    logic [DATA_W-1:0] val_d [DEPTH];
    logic [DATA_W-1:0] idx_d [DEPTH];
    logic [CNT_W-1:0]  cnt_d;

    logic [DATA_W-1:0] relu_v;
    logic              mode_change;
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  better;
    logic [DEPTH-1:0]  slot;
    logic [DEPTH-1:0]  ins_mask;
    logic [DEPTH-1:0]  shift_mask;
    logic              do_insert;

    logic [DATA_W-1:0] rd_v;
    logic [DATA_W-1:0] rd_i;

    // After clamping, the value is non-negative, so unsigned compares are exact.
    assign relu_v      = bus.in[DATA_W-1] ? '0 : bus.in;
    assign mode_change = (bus.asce != asce_q);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CNT_W'(i) < cnt_q);
            if (bus.asce) begin
                better[i] = valid[i] && (relu_v < val_q[i]);
            end else begin
                better[i] = valid[i] && (relu_v > val_q[i]);
            end
            slot[i] = better[i] || !valid[i];
        end
    end

    // Priority pick of the first candidate slot. Every entry behind the
    // insertion point moves down one place; the old last entry falls off.
    always_comb begin : prio_blk
        logic seen;
        seen       = 1'b0;
        ins_mask   = '0;
        shift_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            shift_mask[i] = seen;
            ins_mask[i]   = slot[i] && !seen;
            seen          = seen | slot[i];
        end
    end

    assign do_insert = |slot;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            val_d[i] = val_q[i];
            idx_d[i] = idx_q[i];
        end
        if (mode_change) begin
            // Ordering direction flipped: old contents are meaningless, restart
            // with the current element as the only entry.
            for (int i = 0; i < DEPTH; i++) begin
                val_d[i] = '0;
                idx_d[i] = '0;
            end
            val_d[0] = relu_v;
            idx_d[0] = bus.index;
            cnt_d    = CNT_W'(1);
        end else if (do_insert) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ins_mask[i]) begin
                    val_d[i] = relu_v;
                    idx_d[i] = bus.index;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (shift_mask[i]) begin
                    val_d[i] = val_q[i-1];
                    idx_d[i] = idx_q[i-1];
                end
            end
            if (cnt_q != FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
                idx_q[i] <= '0;
            end
            cnt_q      <= '0;
            asce_q     <= 1'b1;
            head_val_q <= '0;
            head_idx_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= val_d[i];
                idx_q[i] <= idx_d[i];
            end
            cnt_q      <= cnt_d;
            asce_q     <= bus.asce;
            // Entry 0 of the next list is zero whenever the list is empty,
            // so the head needs no separate empty case.
            head_val_q <= val_d[0];
            head_idx_q <= idx_d[0];
        end
    end

    // Decoded read port; invalid entries and addresses beyond DEPTH read 0.
    always_comb begin
        rd_v = '0;
        rd_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((bus.rd_addr == ADDR_W'(i)) && valid[i]) begin
                rd_v = val_q[i];
                rd_i = idx_q[i];
            end
        end
    end

    assign bus.value_out       = head_val_q;
    assign bus.value_index_out = head_idx_q;
    assign bus.count           = cnt_q;
    assign bus.rd_value        = rd_v;
    assign bus.rd_index        = rd_i;

endmodule

// File: tb/tb_sort_relu.sv
// tb_sort_relu
//   Directed bench for sort_relu. Each stimulus step pushes its hand-computed
//   head/count expectation into a queue; a monitor pops one entry after every
//   clock edge that has one and compares. Read-port checks are made directly
//   between edges, while the list is stable.
module tb_sort_relu;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef struct {
        logic [31:0] v;
        logic [31:0] i;
        int          c;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    sort_relu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sort_relu #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #20 clk = ~clk;

    // Monitor: one expectation per stimulus edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.value_out !== e.v || bus.value_index_out !== e.i ||
                    int'(bus.count) != e.c) begin
                    n_errors++;
                    $display("FAIL %s: got value=%0d index=%0d count=%0d, want value=%0d index=%0d count=%0d",
                             e.tag, bus.value_out, bus.value_index_out, bus.count,
                             e.v, e.i, e.c);
                end
            end
        end
    end

    // Drive one element (or a reset edge) and queue the expected head state.
    task automatic step(input string tag, input logic r, input logic a,
                        input logic [31:0] v, input logic [31:0] ix,
                        input logic [31:0] ev, input logic [31:0] ei, input int ec);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.asce  = a;
        bus.in    = v;
        bus.index = ix;
        e.v   = ev;
        e.i   = ei;
        e.c   = ec;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Called right after an edge; finishes well before the next one.
    task automatic rd_check(input string tag, input int addr,
                            input logic [31:0] ev, input logic [31:0] ei);
        bus.rd_addr = ADDR_W'(addr);
        #1;
        n_checks++;
        if (bus.rd_value !== ev || bus.rd_index !== ei) begin
            n_errors++;
            $display("FAIL %s[%0d]: got value=%0d index=%0d, want value=%0d index=%0d",
                     tag, addr, bus.rd_value, bus.rd_index, ev, ei);
        end
    endtask

    initial begin
        logic [31:0] s1_val [7];
        logic [31:0] s1_idx [7];
        int          drain;

        s1_val = '{2, 5, 10, 15, 20, 25, 35};
        s1_idx = '{4, 3, 5, 1, 0, 2, 6};

        bus.in      = '0;
        bus.index   = '0;
        bus.asce    = 1'b1;
        bus.rd_addr = '0;
        rst         = 1'b0;

        step("reset", 0, 1, 0, 0, 0, 0, 0);

        // Ascending fill
        step("asc_a", 1, 1, 20, 0, 20, 0, 1);
        step("asc_b", 1, 1, 15, 1, 15, 1, 2);
        step("asc_c", 1, 1, 25, 2, 15, 1, 3);
        step("asc_d", 1, 1,  5, 3,  5, 3, 4);
        step("asc_e", 1, 1,  2, 4,  2, 4, 5);
        step("asc_f", 1, 1, 10, 5,  2, 4, 6);
        step("asc_g", 1, 1, 35, 6,  2, 4, 7);
        for (int k = 0; k < 7; k++) rd_check("asc_rd", k, s1_val[k], s1_idx[k]);
        rd_check("asc_rd_empty", 7, 0, 0);

        // Reset mid-stream drops the presented element
        step("rst_mid", 0, 1, 42, 3, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) rd_check("rst_rd", k, 0, 0);
        step("after_rst", 1, 1, 42, 3, 42, 3, 1);

        // ReLU clamp of a negative score to the head of an ascending list
        step("relu_rst", 0, 1, 0, 0, 0, 0, 0);
        step("relu_a", 1, 1, 5, 1, 5, 1, 1);
        step("relu_b", 1, 1, 2, 0, 2, 0, 2);
        step("relu_neg", 1, 1, 32'hFFFF_FFF6, 9, 0, 9, 3);
        rd_check("relu_rd", 0, 0, 9);
        rd_check("relu_rd", 1, 2, 0);
        rd_check("relu_rd", 2, 5, 1);

        // Switch to descending: flush, then keep largest first
        step("desc_a", 1, 0, 13, 7, 13, 7, 1);
        step("desc_b", 1, 0, 11, 8, 13, 7, 2);
        step("desc_c", 1, 0,  7, 9, 13, 7, 3);
        step("desc_d", 1, 0, 15, 10, 15, 10, 4);
        step("desc_neg", 1, 0, 32'hFFFF_FFFF, 11, 15, 10, 5);
        rd_check("desc_rd", 0, 15, 10);
        rd_check("desc_rd", 1, 13, 7);
        rd_check("desc_rd", 2, 11, 8);
        rd_check("desc_rd", 3, 7, 9);
        rd_check("desc_rd", 4, 0, 11);

        // Back to ascending: fill to DEPTH, then discard / evict
        step("full_1", 1, 1, 1, 1, 1, 1, 1);
        for (int k = 2; k <= DEPTH; k++) step("full_fill", 1, 1, k, k, 1, 1, k);
        step("full_worse", 1, 1, 9, 9, 1, 1, 8);
        rd_check("full_rd_last", 7, 8, 8);
        step("full_equal", 1, 1, 8, 88, 1, 1, 8);
        rd_check("full_rd_last_eq", 7, 8, 8);
        step("full_best", 1, 1, 0, 99, 0, 99, 8);
        rd_check("full_rd_head", 0, 0, 99);
        rd_check("full_rd_last_ev", 7, 7, 7);

        // Ties: later arrival goes behind the existing equal entry
        step("tie_rst", 0, 1, 0, 0, 0, 0, 0);
        step("tie_a", 1, 1, 5, 0, 5, 0, 1);
        step("tie_b", 1, 1, 5, 1, 5, 0, 2);
        rd_check("tie_rd", 0, 5, 0);
        rd_check("tie_rd", 1, 5, 1);

        drain = 0;
        while (exp_q.size() > 0 && drain < 4) begin
            #5;
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sort_relu.md
Name: sort_relu

Overview:
- Streaming ReLU-plus-top-K sorter for the accelerator post-processing path.
- Each clock it accepts one signed 32-bit score with a 32-bit tag (index) and clamps negative scores to 0 (ReLU).
- Inserts the result into a register-based sorted list of DEPTH entries, keeping the DEPTH best entries (smallest if ascending, largest if descending).
- The best entry is presented continuously on value_out/value_index_out; any entry is readable via a combinational read port.

Parameters:
- DATA_W, 32, width of in, index and all value/index outputs
- DEPTH, 8, number of sorted entries held (≥2)
- ADDR_W, 3, width of rd_addr; must satisfy 2**ADDR_W ≥ DEPTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- in  input  DATA_W  signed two's-complement score, sampled every rising edge
- index  input  DATA_W  tag stored alongside the score
- asce  input  1  1 = ascending (keep smallest, list[0] = min); 0 = descending (keep largest, list[0] = max)
- value_out  output  DATA_W  value of list[0] (registered)
- value_index_out  output  DATA_W  index of list[0] (registered)
- count  output  ADDR_W+1  number of valid entries, 0..DEPTH
- rd_addr  input  ADDR_W  read address into the list
- rd_value  output  DATA_W  combinational value of list[rd_addr]; 0 if invalid or rd_addr ≥ DEPTH
- rd_index  output  DATA_W  combinational index of list[rd_addr]; 0 if invalid or rd_addr ≥ DEPTH

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. On a rising edge with rst=0, all entries are invalid with value and index 0, and count=0, value_out=0, value_index_out=0.
- Input acceptance: with rst=1, one element is accepted on every rising edge; there is no valid/ready handshake.
- ReLU: v = (in[DATA_W-1]==1) ? 0 : in. The index is stored unmodified. After ReLU, comparisons are unsigned.
- Ordering: valid entries occupy list[0..count-1], contiguous.
  - Ascending: list[i].v ≤ list[i+1].v.
  - Descending: list[i].v ≥ list[i+1].v.
- Insertion position: the new element goes at the first position p where it is strictly better than list[p]. Better means < for ascending, > for descending.
  - Ties go after existing equal entries (stable, first arrival wins).
  - Entries p..count-1 shift down one place.
- Not full (count < DEPTH): the element is always inserted and count increments.
- Full (count == DEPTH):
  - If the element is strictly better than list[DEPTH-1], it is inserted and list[DEPTH-1] is dropped; count stays DEPTH.
  - Otherwise it is discarded and the list is unchanged.
- Latency: the whole insertion completes in one cycle. Outputs reflect every element accepted up to and including the last edge.
- Head outputs: value_out/value_index_out equal the post-update list[0]. When the list is empty they are 0.
- Mode change: asce is sampled each edge. If it differs from the value registered on the previous edge, the list is flushed and the current element becomes the sole entry (count=1). The registered asce value resets to 1.
- Reset mid-stream: the element presented on a reset edge is discarded. The first element after reset is inserted normally.
- Implementation: parallel compare of the new element against all entries, a priority one-hot insert mask, and per-entry muxes (hold / shift / load new). No multi-cycle FSM.

Test Plan:
- Ascending, rst=1, asce=1. Feed (in,index) = (20,0)(15,1)(25,2)(5,3)(2,4)(10,5)(35,6) on consecutive edges.
  - Required value_out after each edge: 20,15,15,5,2,2,2; value_index_out: 0,1,1,3,4,4,4.
  - Final rd_value[0..6] = 2,5,10,15,20,25,35; count=7.
- ReLU: in=0xFFFFFFF6 (−10), index=9, while in ascending mode holding {2,5} → value_out=0, value_index_out=9, count=3.
- Descending after flush: asce=0 and feed (13,7)(11,8)(7,9)(15,10).
  - value_out: 13,13,13,15; value_index_out: 7,7,7,10.
  - First edge with asce changed → count=1.
- Full/discard, ascending, DEPTH=8: feed 1..8 (index = value), then 9 → discarded, rd_value[7]=8, count=8. Then feed 0 (index 99) → list[0]=0/99, 8 dropped, rd_value[7]=7.
- Ties, ascending: (5,0) then (5,1) → value_index_out stays 0; rd_index[1]=1.
- Reset mid-operation: after the first scenario, drive rst=0 for one edge → count=0, value_out=0, value_index_out=0, all rd_* = 0. Then (42,3) → value_out=42, index 3, count=1.
